// File: rtl/enc_pb_scan.sv
// enc_pb_scan: front-panel scanner for ENC_CH rotary encoders and ENC_CH pushbuttons.
// Each input bit is synchronised, sampled on a prescaler tick and debounced. A/B pairs
// are quadrature-decoded into saturating signed counts that are read-and-clear.
// Button edges are latched as sticky events.
// Optional feature macro: ENC_SCAN_ACCEL_EN. It turns fast same-direction steps into +/-4.
module enc_pb_scan #(
    parameter  int ENC_CH   = 8,
    parameter  int CNT_W    = 8,
    parameter  int DB_DIV   = 1000,
    parameter  int DB_TICKS = 4,
    localparam int SEL_W    = (ENC_CH > 1) ? $clog2(ENC_CH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [2*ENC_CH-1:0] enc_i,
    input  logic [ENC_CH-1:0]   pb_i,
    input  logic                rd_i,
    input  logic [SEL_W-1:0]    rd_sel_i,
    output logic [CNT_W-1:0]    rd_data_o,
    output logic                rd_valid_o,
    output logic [ENC_CH-1:0]   pb_o,
    output logic [ENC_CH-1:0]   pb_evt_o,
    input  logic [ENC_CH-1:0]   pb_clr_i,
    output logic [ENC_CH-1:0]   err_o,
    output logic                irq_o
);
    localparam int PRE_W = $clog2(DB_DIV);
    localparam int DBC_W = $clog2(DB_TICKS + 1);
    localparam int SUM_W = CNT_W + 4;
    localparam int MAX_I = (1 << (CNT_W - 1)) - 1;
    localparam logic signed [SUM_W-1:0] CNT_MAX = SUM_W'(MAX_I);
    localparam logic signed [SUM_W-1:0] CNT_MIN = SUM_W'(-MAX_I - 1);

    logic [PRE_W-1:0]                pre;
    logic                            tick;
    logic [3*ENC_CH-1:0]             s1, s2;
    logic [ENC_CH-1:0][CNT_W-1:0]    cnt;

    assign tick = (pre == PRE_W'(DB_DIV - 1));

    // Debounce prescaler: one tick every DB_DIV clocks.
    always_ff @(posedge clk_i) begin
        if (rst_i) pre <= '0;
        else       pre <= tick ? '0 : pre + PRE_W'(1);
    end

    // Two-flop synchroniser for all async pins, layout {pb, enc}; deliberately not reset.
    always_ff @(posedge clk_i) begin
        s1 <= {pb_i, enc_i};
        s2 <= s1;
    end

    for (genvar n = 0; n < ENC_CH; n++) begin : g_ch
        logic [2:0]              raw, lvl, lvl_q;   // {pb, A, B}
        logic [2:0][DBC_W-1:0]   dbc;
        logic [1:0]              idx, idx_q, diff;
        logic                    step_up, step_dn, illegal, pb_chg, rd_hit;
        logic signed [SUM_W-1:0] mag, delta, base, sum, sat;
        logic signed [CNT_W-1:0] cnt_r;

        assign raw     = {s2[2*ENC_CH+n], s2[2*n +: 2]};
        // Gray position 00->0, 01->1, 11->2, 10->3; a difference of 2 means both bits moved.
        assign idx     = {lvl[1], ^lvl[1:0]};
        assign idx_q   = {lvl_q[1], ^lvl_q[1:0]};
        assign diff    = idx - idx_q;
        assign step_up = (diff == 2'd1);
        assign step_dn = (diff == 2'd3);
        assign illegal = (diff == 2'd2);
        assign pb_chg  = lvl[2] ^ lvl_q[2];
        assign rd_hit  = rd_i && (rd_sel_i == SEL_W'(n));

`ifdef ENC_SCAN_ACCEL_EN
        logic [7:0] ivl;
        logic       last_up, fast;

        assign fast = ((step_up && last_up) || (step_dn && !last_up)) && (ivl < 8'd8);
        assign mag  = fast ? SUM_W'(4) : SUM_W'(1);

        // Ticks since the last step on this channel; any step (incl. reversal) restarts it.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ivl     <= 8'hFF;
                last_up <= 1'b0;
            end else if (step_up || step_dn) begin
                ivl     <= '0;
                last_up <= step_up;
            end else if (tick && ivl != 8'hFF) begin
                ivl     <= ivl + 8'd1;
            end
        end
`else
        assign mag = SUM_W'(1);
`endif

        assign delta = step_up ? mag : step_dn ? -mag : '0;
        // A read clears the count in the same cycle, but a coincident step survives.
        assign base  = rd_hit ? '0 : SUM_W'(cnt_r);
        assign sum   = base + delta;
        assign sat   = (sum > CNT_MAX) ? CNT_MAX : (sum < CNT_MIN) ? CNT_MIN : sum;

        // Per-bit debounce: DB_TICKS consecutive differing tick samples accept a new level.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                lvl <= {1'b1, raw[1:0]};
                dbc <= '0;
            end else if (tick) begin
                for (int b = 0; b < 3; b++) begin
                    if (raw[b] == lvl[b]) begin
                        dbc[b] <= '0;
                    end else if (dbc[b] == DBC_W'(DB_TICKS - 1)) begin
                        lvl[b] <= raw[b];
                        dbc[b] <= '0;
                    end else begin
                        dbc[b] <= dbc[b] + DBC_W'(1);
                    end
                end
            end
        end

        // Decode one clock after the accepted level moves; update count and sticky flags.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                lvl_q       <= {1'b1, raw[1:0]};
                cnt_r       <= '0;
                pb_evt_o[n] <= 1'b0;
                err_o[n]    <= 1'b0;
            end else begin
                lvl_q       <= lvl;
                cnt_r       <= CNT_W'(sat);
                pb_evt_o[n] <= (pb_evt_o[n] & ~pb_clr_i[n]) | pb_chg;
                err_o[n]    <= (err_o[n] & ~pb_clr_i[n]) | illegal;
            end
        end

        assign cnt[n]  = cnt_r;
        assign pb_o[n] = ~lvl[2];
    end

    // One-deep read port; out-of-range selects return zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_i;
            if (rd_i) rd_data_o <= (int'(rd_sel_i) < ENC_CH) ? cnt[rd_sel_i] : '0;
        end
    end

    // Interrupt: pending motion on any channel or any unacknowledged button event.
    always_ff @(posedge clk_i) begin
        if (rst_i) irq_o <= 1'b0;
        else       irq_o <= (|cnt) || (|pb_evt_o);
    end
endmodule

// File: tb/tb_enc_pb_scan.sv
// tb_enc_pb_scan: randomized and directed checks of enc_pb_scan against a step-level model.
module tb_enc_pb_scan;
    localparam int ENC_CH = 8, CNT_W = 8, DB_DIV = 4, DB_TICKS = 4;
`ifdef ENC_SCAN_ACCEL_EN
    localparam int ACC_EXP = 9;
`else
    localparam int ACC_EXP = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, rd, rd4, rd_valid, rd_valid4, irq, irq4;
    logic [2*ENC_CH-1:0] enc;
    logic [ENC_CH-1:0]   pb, pb_o, pb_evt, pb_clr, err;
    logic [2:0]          rd_sel, pb_o4, pb_evt4, err4;
    logic [1:0]          rd_sel4;
    logic [CNT_W-1:0]    rd_data;
    logic [3:0]          rd_data4;

    enc_pb_scan #(.ENC_CH(ENC_CH), .CNT_W(CNT_W), .DB_DIV(DB_DIV), .DB_TICKS(DB_TICKS)) dut (
        .clk_i(clk), .rst_i(rst), .enc_i(enc), .pb_i(pb), .rd_i(rd), .rd_sel_i(rd_sel),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .pb_o(pb_o), .pb_evt_o(pb_evt),
        .pb_clr_i(pb_clr), .err_o(err), .irq_o(irq));

    enc_pb_scan #(.ENC_CH(3), .CNT_W(4), .DB_DIV(DB_DIV), .DB_TICKS(DB_TICKS)) dut4 (
        .clk_i(clk), .rst_i(rst), .enc_i(enc[5:0]), .pb_i(pb[2:0]), .rd_i(rd4), .rd_sel_i(rd_sel4),
        .rd_data_o(rd_data4), .rd_valid_o(rd_valid4), .pb_o(pb_o4), .pb_evt_o(pb_evt4),
        .pb_clr_i(pb_clr[2:0]), .err_o(err4), .irq_o(irq4));

    // Model: physical encoder position and expected counts for both instances.
    int pos[ENC_CH];
    int exp8[ENC_CH];
    int exp4[3];
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic logic [1:0] gray(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic wait_ticks(input int n);
        repeat (n * DB_DIV) @(negedge clk);
    endtask

    // One detent in direction dir (+1 = CW) on channel ch.
    task automatic move(input int ch, input int dir);
        pos[ch] += dir;
        enc[2*ch +: 2] = gray(pos[ch]);
        exp8[ch] = sat(exp8[ch] + dir, CNT_W);
        if (ch < 3) exp4[ch] = sat(exp4[ch] + dir, 4);
    endtask

    task automatic rd_main(input int sel, input int want, input string tag);
        rd = 1'b1; rd_sel = 3'(sel);
        @(negedge clk); rd = 1'b0;
        chk({tag, "_vld"}, int'(rd_valid), 1);
        chk(tag, int'($signed(rd_data)), want);
        @(negedge clk);
        chk({tag, "_vld_low"}, int'(rd_valid), 0);
        chk({tag, "_hold"}, int'($signed(rd_data)), want);
        exp8[sel] = 0;
    endtask

    task automatic rd_sub(input int sel, input int want, input string tag);
        rd4 = 1'b1; rd_sel4 = 2'(sel);
        @(negedge clk); rd4 = 1'b0;
        chk({tag, "_vld"}, int'(rd_valid4), 1);
        chk(tag, int'($signed(rd_data4)), want);
        @(negedge clk);
        chk({tag, "_vld_low"}, int'(rd_valid4), 0);
        if (sel < 3) exp4[sel] = 0;
    endtask

    task automatic clear_flags();
        pb_clr = '1;
        @(negedge clk); pb_clr = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  ch, dir, want;
        bit  seen;
        logic old7;

        rst = 1'b1; enc = '0; pb = '1; rd = 1'b0; rd4 = 1'b0;
        rd_sel = '0; rd_sel4 = '0; pb_clr = '0;
        for (int i = 0; i < ENC_CH; i++) begin pos[i] = 0; exp8[i] = 0; end
        for (int i = 0; i < 3; i++) exp4[i] = 0;
        repeat (5) @(negedge clk);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_pb_o", int'(pb_o), 0);
        chk("rst_pb_evt", int'(pb_evt), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_irq", int'(irq), 0);
        rst = 1'b0;
        wait_ticks(10);
        chk("post_rst_irq", int'(irq), 0);

        // Bounce on button 0: low, high, low one tick each, then held low.
        pb[0] = 1'b0; repeat (4) @(negedge clk);
        pb[0] = 1'b1; repeat (4) @(negedge clk);
        pb[0] = 1'b0;
        repeat (14) @(negedge clk);
        chk("pb_early", int'(pb_o[0]), 0);
        repeat (4) @(negedge clk);
        chk("pb_accept", int'(pb_o[0]), 1);
        repeat (2) @(negedge clk);
        chk("pb_evt_set", int'(pb_evt), 1);
        chk("pb_irq_set", int'(irq), 1);
        clear_flags();
        chk("pb_evt_clr", int'(pb_evt), 0);
        chk("pb_irq_clr", int'(irq), 0);
        pb[0] = 1'b1; wait_ticks(10);
        chk("pb_release", int'(pb_o[0]), 0);
        chk("pb_evt_rel", int'(pb_evt[0]), 1);
        clear_flags();

        // Eight clean CW detents on channel 3.
        for (int i = 0; i < 8; i++) begin move(3, 1); wait_ticks(20); end
        chk("cw_irq", int'(irq), 1);
        rd_main(3, exp8[3], "cw_read");
        rd_main(3, exp8[3], "cw_reread");
        chk("cw_irq_clr", int'(irq), 0);

        // Both A and B flip in one sample on channel 0.
        pos[0] = 2; enc[1:0] = 2'b11; wait_ticks(10);
        chk("ill_err", int'(err), 1);
        rd_main(0, exp8[0], "ill_cnt");
        clear_flags();
        chk("ill_err_clr", int'(err), 0);

        // Collision: step lands in the read cycle. pb[7] flips together with the
        // encoder bit, so its debounced edge marks the cycle the step is accepted.
        rd_main(1, exp8[1], "col_pre");
        for (int i = 0; i < 5; i++) begin move(1, 1); wait_ticks(10); end
        want = exp8[1];
        old7 = pb_o[7];
        move(1, 1); pb[7] = ~pb[7];
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (pb_o[7] != old7) seen = 1'b1;
        end
        chk("col_seen", int'(seen), 1);
        rd = 1'b1; rd_sel = 3'd1;
        @(negedge clk); rd = 1'b0;
        chk("col_vld", int'(rd_valid), 1);
        chk("col_data", int'($signed(rd_data)), want);
        exp8[1] = 1;
        wait_ticks(4);
        rd_main(1, exp8[1], "col_next");
        pb[7] = 1'b1; wait_ticks(10);
        clear_flags();

        // Saturation on the 4-bit instance, channel 0.
        rd_main(0, exp8[0], "sat_clr8");
        rd_sub(0, exp4[0], "sat_clr4");
        for (int i = 0; i < 10; i++) begin move(0, -1); wait_ticks(10); end
        rd_sub(0, exp4[0], "sat_neg");
        for (int i = 0; i < 20; i++) begin move(0, 1); wait_ticks(10); end
        rd_sub(0, exp4[0], "sat_pos");
        rd_main(0, exp8[0], "sat_main");
        rd_sub(3, 0, "sel_oor");

        // Closely spaced steps (accelerated when enabled), then widely spaced ones.
        rd_sub(2, exp4[2], "acc_clr4");
        for (int i = 0; i < 3; i++) begin move(2, 1); wait_ticks(2); end
        wait_ticks(10);
        exp8[2] = ACC_EXP;
        exp4[2] = sat(ACC_EXP, 4);
        rd_main(2, exp8[2], "acc_fast");
        rd_sub(2, exp4[2], "acc_fast4");
        for (int i = 0; i < 3; i++) begin move(2, 1); wait_ticks(20); end
        rd_main(2, exp8[2], "acc_slow");
        rd_sub(2, exp4[2], "acc_slow4");

        // Randomized detents and reads.
        for (int it = 0; it < 40; it++) begin
            ch  = $urandom_range(0, ENC_CH - 1);
            dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
            move(ch, dir);
            wait_ticks(10);
            if ($urandom_range(0, 2) == 0) begin
                ch = $urandom_range(0, ENC_CH - 1);
                rd_main(ch, exp8[ch], "rnd_rd");
            end
            if ($urandom_range(0, 3) == 0) begin
                ch = $urandom_range(0, 3);
                rd_sub(ch, (ch < 3) ? exp4[ch] : 0, "rnd_rd4");
            end
        end
        chk("rnd_err", int'(err), 0);
        for (int i = 0; i < ENC_CH; i++) rd_main(i, exp8[i], "rnd_final");
        for (int i = 0; i < 3; i++) rd_sub(i, exp4[i], "rnd_final4");

        // Reset in the middle of a debounce with a read in flight.
        move(4, 1);
        repeat (10) @(negedge clk);
        rd = 1'b1; rd_sel = 3'd4; rst = 1'b1;
        @(negedge clk); rd = 1'b0;
        chk("mid_rst_vld", int'(rd_valid), 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_pb", int'(pb_o), 0);
        chk("mid_rst_irq", int'(irq), 0);
        chk("mid_rst_data", int'(rd_data), 0);
        rst = 1'b0;
        for (int i = 0; i < ENC_CH; i++) exp8[i] = 0;
        wait_ticks(10);
        chk("mid_rst_err", int'(err), 0);
        rd_main(4, exp8[4], "mid_rst_cnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
